// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-subtract step per cycle on magnitudes, sign fix-up in a final cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               isDiv_q, isDiv_d;
    logic               negRes_q, negRes_d;
    logic               signA_q, signA_d;
    logic               divZero_q, divZero_d;
    logic               done_q, done_d;

    logic               isSignedOp;
    logic               isArithOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prodNeg;

    assign isSignedOp = (op == MDU_MULT) || (op == MDU_DIV);
    assign isArithOp  = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    assign aNeg       = isSignedOp & rs_data[WIDTH-1];
    assign bNeg       = isSignedOp & rt_data[WIDTH-1];

    // The accumulator is shared: mult shifts right with the product growing in the
    // top half; div shifts left with remainder on top and quotient filling the bottom.
    assign addSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opB_q};
    assign remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = remShift - {1'b0, opB_q};
    assign prodNeg  = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        signA_d   = signA_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && isArithOp) begin
                    acc_d     = {{WIDTH{1'b0}}, condNeg(rs_data, aNeg)};
                    opB_d     = condNeg(rt_data, bNeg);
                    isDiv_d   = (op == MDU_DIV) || (op == MDU_DIVU);
                    negRes_d  = aNeg ^ bNeg;
                    signA_d   = aNeg;
                    divZero_d = (rt_data == '0);
                    count_d   = '0;
                    state_d   = ST_RUN;
                end else if (start && op == MDU_MTHI) begin
                    hi_d = rs_data;
                end else if (start && op == MDU_MTLO) begin
                    lo_d = rs_data;
                end
            end
            ST_RUN: begin
                if (isDiv_q) begin
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    if (acc_q[0])
                        acc_d = {addSum, acc_q[WIDTH-1:1]};
                    else
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                // A zero divisor leaves remainder = |rs|, so the dividend-sign fix-up
                // alone restores the raw rs value in HI; only LO needs forcing.
                if (isDiv_q) begin
                    lo_d = divZero_q ? '1 : condNeg(acc_q[WIDTH-1:0], negRes_q);
                    hi_d = condNeg(acc_q[2*WIDTH-1:WIDTH], signA_q);
                end else begin
                    {hi_d, lo_d} = negRes_q ? prodNeg : acc_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            signA_q   <= 1'b0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            signA_q   <= signA_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: each scenario task drives its own vectors
// and compares against hand-computed results.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a one-cycle start strobe; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy samples (one per negedge) until busy drops, bounded.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_latency;
        int cycles;
        int doneSeen;
        issue(mdu_pkg::MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycles = 0;
        doneSeen = 0;
        while (busy === 1'b1 && cycles < 200) begin
            if (done === 1'b1) doneSeen++;
            if (hi !== 32'h0 || lo !== 32'h0) doneSeen += 100;
            cycles++;
            @(negedge clk);
        end
        checks++; if (cycles !== 33) begin failures++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=33", cycles); end
        checks++; if (doneSeen !== 0) begin failures++; $display("[TB] FAIL multu_quiet_during_run got=%0d exp=0", doneSeen); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL multu_done got=%b exp=1", done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=00000001", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL multu_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_signed;
        int cycles;
        issue(mdu_pkg::MDU_MULT, 32'hFFFF_FFF9, 32'd6);
        waitIdle(cycles);
        checks++; if (cycles !== 33) begin failures++; $display("[TB] FAIL mult_cycles got=%0d exp=33", cycles); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFD6) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=ffffffd6", lo); end
        issue(mdu_pkg::MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        waitIdle(cycles);
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL div_done got=%b exp=1", done); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_hi got=%h exp=ffffffff", hi); end
        issue(mdu_pkg::MDU_DIVU, 32'd1000, 32'd7);
        waitIdle(cycles);
        checks++; if (lo !== 32'd142) begin failures++; $display("[TB] FAIL divu_lo got=%h exp=%h", lo, 32'd142); end
        checks++; if (hi !== 32'd6) begin failures++; $display("[TB] FAIL divu_hi got=%h exp=%h", hi, 32'd6); end
    endtask

    task automatic test_div_edge;
        int cycles;
        issue(mdu_pkg::MDU_DIVU, 32'd100, 32'd0);
        waitIdle(cycles);
        checks++; if (cycles !== 33) begin failures++; $display("[TB] FAIL divzero_cycles got=%0d exp=33", cycles); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divuzero_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin failures++; $display("[TB] FAIL divuzero_hi got=%h exp=%h", hi, 32'd100); end
        issue(mdu_pkg::MDU_DIV, 32'hFFFF_FFF9, 32'd0);
        waitIdle(cycles);
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFF9) begin failures++; $display("[TB] FAIL divzero_hi got=%h exp=fffffff9", hi); end
        issue(mdu_pkg::MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(cycles);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("[TB] FAIL divovf_hi got=%h exp=0", hi); end
    endtask

    task automatic test_mthi_mtlo;
        int cycles;
        issue(mdu_pkg::MDU_MTHI, 32'h1234_5678, 32'h0);
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mthi_quiet got=%b%b exp=00", busy, done); end
        issue(mdu_pkg::MDU_MTLO, 32'h9ABC_DEF0, 32'h0);
        checks++; if (lo !== 32'h9ABC_DEF0) begin failures++; $display("[TB] FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("[TB] FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mtlo_quiet got=%b%b exp=00", busy, done); end
        issue(3'd6, 32'h5555_5555, 32'h1);
        checks++; if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            failures++; $display("[TB] FAIL undef_op got busy=%b hi=%h lo=%h exp 0/12345678/9abcdef0", busy, hi, lo);
        end
        issue(mdu_pkg::MDU_DIVU, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        issue(mdu_pkg::MDU_MTLO, 32'hDEAD_BEEF, 32'd3);
        checks++; if (lo !== 32'h9ABC_DEF0 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL mtlo_while_busy got lo=%h busy=%b exp 9abcdef0/1", lo, busy);
        end
        waitIdle(cycles);
        checks++; if (cycles !== 26) begin failures++; $display("[TB] FAIL inflight_cycles got=%0d exp=26", cycles); end
        checks++; if (lo !== 32'd142 || hi !== 32'd6) begin
            failures++; $display("[TB] FAIL inflight_result got hi=%h lo=%h exp 6/8e", hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        int cycles;
        issue(mdu_pkg::MDU_MULT, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL abort_ctrl got=%b%b exp=00", busy, done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("[TB] FAIL abort_hilo got hi=%h lo=%h exp 0/0", hi, lo); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || hi !== 32'h0) begin failures++; $display("[TB] FAIL abort_no_done got done=%b hi=%h exp 0/0", done, hi); end
        issue(mdu_pkg::MDU_MULT, 32'd3, 32'hFFFF_FFFB);
        waitIdle(cycles);
        checks++; if (cycles !== 33 || done !== 1'b1) begin failures++; $display("[TB] FAIL restart_ctrl got cycles=%0d done=%b exp 33/1", cycles, done); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++; $display("[TB] FAIL restart_result got hi=%h lo=%h exp ffffffff/fffffff1", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        int n;
        issue(mdu_pkg::MDU_DIVU, 32'd50, 32'd7);
        waitIdle(cycles);
        checks++; if (done !== 1'b1 || lo !== 32'd7 || hi !== 32'd1) begin
            failures++; $display("[TB] FAIL b2b_first got done=%b hi=%h lo=%h exp 1/1/7", done, hi, lo);
        end
        start   = 1'b1;
        op      = mdu_pkg::MDU_DIVU;
        rs_data = 32'hFFFF_FFFF;
        rt_data = 32'd16;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (done !== 1'b1 && n < 100);
        checks++; if (n !== 34) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=34", n); end
        checks++; if (lo !== 32'h0FFF_FFFF || hi !== 32'd15) begin
            failures++; $display("[TB] FAIL b2b_second got hi=%h lo=%h exp f/0fffffff", hi, lo);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        test_reset;
        test_multu_latency;
        test_signed;
        test_div_edge;
        test_mthi_mtlo;
        test_reset_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
